// File: rtl/tl_phase_sched_if.sv
// Request/status bundle between the controller front end and the phase scheduler.
// Signal names match the scheduler's external pin list.
interface tl_phase_sched_if;
  logic       i_tick;
  logic       i_req_ns;
  logic       i_req_ew;
  logic       i_preempt;
  logic       i_preempt_dir;
  logic [2:0] o_state;
  logic       o_pend_ns;
  logic       o_pend_ew;
  logic       o_served_ns;
  logic       o_served_ew;

  modport master (
    output i_tick, i_req_ns, i_req_ew, i_preempt, i_preempt_dir,
    input  o_state, o_pend_ns, o_pend_ew, o_served_ns, o_served_ew
  );

  modport slave (
    input  i_tick, i_req_ns, i_req_ew, i_preempt, i_preempt_dir,
    output o_state, o_pend_ns, o_pend_ew, o_served_ns, o_served_ew
  );
endinterface

// File: rtl/tl_phase_sched.sv
// Demand-actuated NS/EW phase scheduler: min/max green, yellow, all-red clearance,
// demand latching and emergency preemption; steps only on the i_tick enable.
module tl_phase_sched #(
  parameter int                   T_WIDTH    = 12,
  parameter logic [T_WIDTH-1:0]   START_TIME = 12'd20,
  parameter logic [T_WIDTH-1:0]   MIN_GREEN  = 12'd100,
  parameter logic [T_WIDTH-1:0]   MAX_GREEN  = 12'd600,
  parameter logic [T_WIDTH-1:0]   Y_TIME     = 12'd30,
  parameter logic [T_WIDTH-1:0]   AR_TIME    = 12'd10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  tl_phase_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_START, ST_NS_G, ST_NS_Y, ST_AR_EW, ST_EW_G, ST_EW_Y, ST_AR_NS
  } state_e;

  localparam logic [T_WIDTH-1:0] START_LAST = START_TIME - 1'b1;
  localparam logic [T_WIDTH-1:0] MIN_LAST   = MIN_GREEN - 1'b1;
  localparam logic [T_WIDTH-1:0] MAX_LAST   = MAX_GREEN - 1'b1;
  localparam logic [T_WIDTH-1:0] Y_LAST     = Y_TIME - 1'b1;
  localparam logic [T_WIDTH-1:0] AR_LAST    = AR_TIME - 1'b1;
  localparam logic [T_WIDTH-1:0] T_SAT      = '1;

  state_e             state_q, state_d;
  logic [T_WIDTH-1:0] timer_q, timer_d;
  logic               pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic               served_ns_q, served_ns_d, served_ew_q, served_ew_d;
  logic [2:0]         code_q, code_d;

  logic pre_ns, pre_ew, ns_enter, ew_enter;

  assign pre_ns = bus.i_preempt & ~bus.i_preempt_dir;
  assign pre_ew = bus.i_preempt &  bus.i_preempt_dir;

  // Next phase; a preempted direction already in green simply rests there.
  always_comb begin
    state_d = state_q;
    if (bus.i_tick) begin
      case (state_q)
        ST_START: if (timer_q == START_LAST) state_d = pre_ew ? ST_EW_G : ST_NS_G;
        ST_NS_G: begin
          if (pre_ew)
            state_d = ST_NS_Y;
          else if (!pre_ns && pend_ew_q &&
                   ((timer_q >= MIN_LAST && !bus.i_req_ns) || timer_q >= MAX_LAST))
            state_d = ST_NS_Y;
        end
        ST_NS_Y:  if (timer_q == Y_LAST)  state_d = ST_AR_EW;
        ST_AR_EW: if (timer_q == AR_LAST) state_d = ST_EW_G;
        ST_EW_G: begin
          if (pre_ns)
            state_d = ST_EW_Y;
          else if (!pre_ew && pend_ns_q &&
                   ((timer_q >= MIN_LAST && !bus.i_req_ew) || timer_q >= MAX_LAST))
            state_d = ST_EW_Y;
        end
        ST_EW_Y:  if (timer_q == Y_LAST)  state_d = ST_AR_NS;
        ST_AR_NS: if (timer_q == AR_LAST) state_d = ST_NS_G;
        default:  state_d = ST_START;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (bus.i_tick && timer_q != T_SAT)
      timer_d = timer_q + 1'b1;
  end

  assign ns_enter = (state_d == ST_NS_G) && (state_q != ST_NS_G);
  assign ew_enter = (state_d == ST_EW_G) && (state_q != ST_EW_G);

  // Clearing on green entry takes priority over a same-cycle set.
  always_comb begin
    pend_ns_d   = pend_ns_q | ((bus.i_req_ns | pre_ns) & (state_q != ST_NS_G));
    pend_ew_d   = pend_ew_q | ((bus.i_req_ew | pre_ew) & (state_q != ST_EW_G));
    if (ns_enter) pend_ns_d = 1'b0;
    if (ew_enter) pend_ew_d = 1'b0;
    served_ns_d = ns_enter;
    served_ew_d = ew_enter;
  end

  always_comb begin
    code_d = 3'b111;
    case (state_d)
      ST_NS_G: code_d = 3'b011;
      ST_NS_Y: code_d = 3'b010;
      ST_EW_G: code_d = 3'b000;
      ST_EW_Y: code_d = 3'b001;
      default: code_d = 3'b111;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_START;
      timer_q     <= '0;
      pend_ns_q   <= 1'b0;
      pend_ew_q   <= 1'b0;
      served_ns_q <= 1'b0;
      served_ew_q <= 1'b0;
      code_q      <= 3'b111;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pend_ns_q   <= pend_ns_d;
      pend_ew_q   <= pend_ew_d;
      served_ns_q <= served_ns_d;
      served_ew_q <= served_ew_d;
      code_q      <= code_d;
    end
  end

  assign bus.o_state     = code_q;
  assign bus.o_pend_ns   = pend_ns_q;
  assign bus.o_pend_ew   = pend_ew_q;
  assign bus.o_served_ns = served_ns_q;
  assign bus.o_served_ew = served_ew_q;

endmodule
